wide_add_sequencer: RTL and testbench

Multi-precision add/subtract controller that runs operands of up to MAX_WORDS × WORD_W bits through one shared single-cycle 32-bit Brent-Kung adder, one word per cycle, least-significant word first. The carry is held in a register between words. Upstream supplies a command followed by a stream of word pairs; downstream receives one sum word per input word, and the final beat carries the flags. The block sits between the lab's operand buffer and result sink, and it is the only owner of the adder instance.

---
 rtl/wide_add_pkg.sv | 23 ++
 rtl/brent_kung_adder_32bit.sv | 49 ++++
 rtl/wide_add_sequencer.sv | 151 +++++++++++++++
 tb/tb_wide_add_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package wide_add_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    // 0 behaves as a single word; oversize requests saturate at the maximum.
    function automatic int unsigned clamp_nwords(input int unsigned n,
                                                 input int unsigned max_words);
        if (n == 0) begin
            return 1;
        end else if (n > max_words) begin
            return max_words;
        end
        return n;
    endfunction

endpackage

// File: rtl/brent_kung_adder_32bit.sv
// Single-cycle 32-bit Brent-Kung parallel-prefix adder with carry-in and carry-out.
module brent_kung_adder_32bit (
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    input  logic        cin,
    output logic [31:0] out_res,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] gg;
    logic [31:0] pp;
    logic [32:0] c;

    assign g = in_op1 & in_op2;
    assign p = in_op1 ^ in_op2;

    always_comb begin
        gg = g;
        pp = p;
        // Up-sweep: build group terms at positions 2^k-aligned.
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end
        // Down-sweep: fill in the remaining prefix positions.
        for (int l = 3; l >= 0; l--) begin
            for (int i = 0; i < 32; i++) begin
                if ((((i + 1) % (2 << l)) == 0) && ((i + (1 << l)) < 32)) begin
                    gg[i + (1 << l)] = gg[i + (1 << l)] | (pp[i + (1 << l)] & gg[i]);
                    pp[i + (1 << l)] = pp[i + (1 << l)] & pp[i];
                end
            end
        end
        c[0] = cin;
        for (int i = 0; i < 32; i++) begin
            c[i + 1] = gg[i] | (pp[i] & cin);
        end
    end

    assign out_res = p ^ c[31:0];
    assign cout    = c[32];

endmodule

// File: rtl/wide_add_sequencer.sv
// Word-serial multi-precision add/subtract, LSW first, through one shared 32-bit adder.
module wide_add_sequencer #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_nwords,
    input  logic              cmd_sub,
    input  logic              cmd_cin,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_op1,
    input  logic [WORD_W-1:0] in_op2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_carry,
    output logic              out_ovf,
    output logic              busy
);
    import wide_add_pkg::*;

    localparam int unsigned Msb = WORD_W - 1;

    state_e             state_q, state_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic [WORD_W-1:0]  out_sum_q, out_sum_d;
    logic               out_last_q, out_last_d;
    logic               out_carry_q, out_carry_d;
    logic               out_ovf_q, out_ovf_d;

    logic [WORD_W-1:0]  add_op2;
    logic [WORD_W-1:0]  add_sum;
    logic               add_cout;
    logic [CNT_W-1:0]   n_eff;
    logic               in_fire;
    logic               out_fire;
    logic               idx_last;

    assign add_op2 = in_op2 ^ {WORD_W{sub_q}};

    brent_kung_adder_32bit u_adder (
        .in_op1  (in_op1),
        .in_op2  (add_op2),
        .cin     (carry_q),
        .out_res (add_sum),
        .cout    (add_cout)
    );

    assign n_eff     = CNT_W'(clamp_nwords(32'(cmd_nwords), MAX_WORDS));
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    // Single output register: a drain in the same cycle frees it for a new word.
    assign in_ready  = (state_q == StRun) && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign idx_last  = (idx_q == (n_q - CNT_W'(1)));

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        n_d         = n_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    sub_d   = cmd_sub;
                    n_d     = n_eff;
                    carry_d = cmd_cin ^ cmd_sub;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                end
                if (in_fire) begin
                    out_sum_d   = add_sum;
                    out_valid_d = 1'b1;
                    carry_d     = add_cout;
                    if (idx_last) begin
                        out_last_d  = 1'b1;
                        out_carry_d = add_cout ^ sub_q;
                        out_ovf_d   = (in_op1[Msb] ^ add_op2[Msb] ^ add_sum[Msb]) ^ add_cout;
                        state_d     = StFlush;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            StFlush: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            n_q         <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed, table-driven bench for wide_add_sequencer with hand-computed results.
module tb_wide_add_sequencer;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned MAX_WORDS = 8;
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_nwords;
    logic              cmd_sub;
    logic              cmd_cin;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_op1;
    logic [WORD_W-1:0] in_op2;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_sum;
    logic              out_last;
    logic              out_carry;
    logic              out_ovf;
    logic              busy;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        string             name;
        logic [CNT_W-1:0]  nwords;
        logic              sub;
        logic              cin;
        bit                toggle;
        logic [7:0][31:0]  op1;
        logic [7:0][31:0]  op2;
        logic [7:0][31:0]  exp_sum;
        logic              exp_carry;
        logic              exp_ovf;
    } vec_t;

    vec_t vecs[10];

    wide_add_sequencer #(
        .WORD_W    (WORD_W),
        .MAX_WORDS (MAX_WORDS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_nwords (cmd_nwords),
        .cmd_sub    (cmd_sub),
        .cmd_cin    (cmd_cin),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_last   (out_last),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sum"},   out_sum,        32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_out_carry"}, 32'(out_carry), 32'd0);
        check({tag, "_out_ovf"},   32'(out_ovf),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Called at a negedge; leaves the bench at a negedge with the block idle again.
    task automatic run_op(input vec_t v);
        int   n;
        int   in_i;
        int   out_i;
        int   cyc;
        bit   stall_prev;
        bit   fire_prev;
        logic [31:0] held_sum;

        n = (v.nwords == 0) ? 1 : ((v.nwords > MAX_WORDS) ? MAX_WORDS : int'(v.nwords));
        for (int k = 0; k < 20 && !cmd_ready; k++) @(negedge clk);
        check({v.name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_nwords = v.nwords;
        cmd_sub    = v.sub;
        cmd_cin    = v.cin;
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
        check({v.name, "_busy"}, 32'(busy), 32'd1);

        in_i       = 0;
        out_i      = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        fire_prev  = 1'b0;
        held_sum   = '0;
        while (out_i < n && cyc < 200) begin
            out_ready = v.toggle ? ((cyc % 2) == 0) : 1'b1;
            in_valid  = (in_i < n);
            in_op1    = (in_i < n) ? v.op1[in_i] : 32'h0;
            in_op2    = (in_i < n) ? v.op2[in_i] : 32'h0;
            #1;
            check({v.name, "_cmd_held_off"}, 32'(cmd_ready), 32'd0);
            if (fire_prev) check({v.name, "_latency"}, 32'(out_valid), 32'd1);
            if (stall_prev) begin
                check({v.name, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({v.name, "_hold_sum"}, out_sum, held_sum);
            end
            if (out_valid && !out_ready)
                check({v.name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                check($sformatf("%s_sum%0d", v.name, out_i), out_sum, v.exp_sum[out_i]);
                check($sformatf("%s_last%0d", v.name, out_i), 32'(out_last),
                      32'(out_i == n - 1));
                if (out_i == n - 1) begin
                    check({v.name, "_carry"}, 32'(out_carry), 32'(v.exp_carry));
                    check({v.name, "_ovf"}, 32'(out_ovf), 32'(v.exp_ovf));
                end
                out_i++;
            end
            fire_prev  = in_valid && in_ready;
            if (fire_prev) in_i++;
            stall_prev = out_valid && !out_ready;
            held_sum   = out_sum;
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({v.name, "_all_words"}, 32'(out_i), 32'(n));
        check({v.name, "_inputs_used"}, 32'(in_i), 32'(n));
        #1;
        check({v.name, "_idle_after"}, 32'(cmd_ready), 32'd1);
        check({v.name, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    function automatic vec_t mk(input string name, input logic [CNT_W-1:0] nw, input logic sub,
                                input logic cin, input bit tog, input logic carry,
                                input logic ovf);
        vec_t v;
        v.name      = name;
        v.nwords    = nw;
        v.sub       = sub;
        v.cin       = cin;
        v.toggle    = tog;
        v.op1       = '0;
        v.op2       = '0;
        v.exp_sum   = '0;
        v.exp_carry = carry;
        v.exp_ovf   = ovf;
        return v;
    endfunction

    initial begin
        vec_t rv;

        vecs[0] = mk("add1_wrap", 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[0].op1[0] = 32'hFFFF_FFFF; vecs[0].op2[0] = 32'h1; vecs[0].exp_sum[0] = 32'h0;

        vecs[1] = mk("add2_chain", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1].op1[0] = 32'hFFFF_FFFF; vecs[1].op2[0] = 32'h1;
        vecs[1].exp_sum[0] = 32'h0; vecs[1].exp_sum[1] = 32'h1;

        vecs[2] = mk("sub2_borrow", 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[2].op2[0] = 32'h1;
        vecs[2].exp_sum[0] = 32'hFFFF_FFFF; vecs[2].exp_sum[1] = 32'hFFFF_FFFF;

        vecs[3] = mk("add1_ovf", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[3].op1[0] = 32'h7FFF_FFFF; vecs[3].op2[0] = 32'h1;
        vecs[3].exp_sum[0] = 32'h8000_0000;

        vecs[4] = mk("sub1_bin", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4].op1[0] = 32'd5; vecs[4].op2[0] = 32'd3; vecs[4].exp_sum[0] = 32'd1;

        vecs[5] = mk("n0_as_1", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5].op1[0] = 32'd3; vecs[5].op2[0] = 32'd4; vecs[5].exp_sum[0] = 32'd8;

        vecs[6] = mk("n15_clamp", 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) vecs[6].op1[i] = 32'hFFFF_FFFF;
        vecs[6].op2[0] = 32'h1;

        vecs[7] = mk("sub1_ovf", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[7].op1[0] = 32'h8000_0000; vecs[7].op2[0] = 32'h1;
        vecs[7].exp_sum[0] = 32'h7FFF_FFFF;

        vecs[8] = mk("bp4_toggle", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vecs[8].op1[i]     = 32'(i + 1);
            vecs[8].op2[i]     = 32'(10 * (i + 1));
            vecs[8].exp_sum[i] = 32'(11 * (i + 1));
        end

        vecs[9] = mk("sub3_mixed", 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[9].op1[0] = 32'h0000_0000; vecs[9].op2[0] = 32'h0000_0001;
        vecs[9].op1[1] = 32'h0000_0005; vecs[9].op2[1] = 32'h0000_0002;
        vecs[9].op1[2] = 32'h0000_0001; vecs[9].op2[2] = 32'h0000_0000;
        vecs[9].exp_sum[0] = 32'hFFFF_FFFF;
        vecs[9].exp_sum[1] = 32'h0000_0002;
        vecs[9].exp_sum[2] = 32'h0000_0001;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_nwords = '0;
        cmd_sub    = 1'b0;
        cmd_cin    = 1'b0;
        in_valid   = 1'b0;
        in_op1     = '0;
        in_op2     = '0;
        out_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Reset after two of four words: partial result must vanish with no last beat.
        cmd_valid  = 1'b1;
        cmd_nwords = 4'd4;
        cmd_sub    = 1'b0;
        cmd_cin    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_op1   = 32'(100 + i);
            in_op2   = 32'(1);
            @(posedge clk);
            @(negedge clk);
        end
        in_op1   = 32'hFFFF_FFFF;
        in_op2   = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_out", 32'(out_valid), 32'd0);
        end

        rv = mk("post_rst", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rv.op1[0] = 32'd3; rv.op2[0] = 32'd4; rv.exp_sum[0] = 32'd7;
        run_op(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
